// File: rtl/wb_bram_bridge.sv
// Wishbone classic slave to single-port BRAM request/READY bridge.
// Optional READY watchdog: define BRIDGE_TIMEOUT_EN.
module wb_bram_bridge #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        EN0,
    output logic [3:0]  WE0,
    output logic [31:0] A0,
    output logic [31:0] Di0,
    input  logic [31:0] Do0,
    input  logic        READY,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] a_q, a_d;
    logic [31:0] di_q, di_d;
    logic [31:0] dat_q, dat_d;
    logic        wr_q, wr_d;
    logic        ack_q, ack_d;
    logic        abort_q, abort_d;
    logic        aborting;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign aborting   = abort_q | ~wbs_cyc_i;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        we_d    = we_q;
        a_d     = a_q;
        di_d    = di_q;
        dat_d   = dat_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        abort_d = abort_q;
`ifdef BRIDGE_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    a_d     = {2'b0, wbs_adr_i[31:2]};
                    di_d    = wbs_dat_i;
                    we_d    = wbs_we_i ? wbs_sel_i : 4'b0;
                    wr_d    = wbs_we_i;
                    en_d    = 1'b1;
                    abort_d = 1'b0;
                    state_d = REQ;
`ifdef BRIDGE_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            REQ: begin
                // A dropped cycle still waits for READY so the memory
                // never sees a request vanish before it completes.
                abort_d = aborting;
                if (READY) begin
                    en_d    = 1'b0;
                    we_d    = 4'b0;
                    dat_d   = wr_q ? 32'h0 : Do0;
                    ack_d   = ~aborting;
                    state_d = RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    en_d    = 1'b0;
                    we_d    = 4'b0;
                    dat_d   = ERR_DATA;
                    err_d   = 1'b1;
                    ack_d   = ~aborting;
                    state_d = RESP;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            we_q    <= 4'b0;
            a_q     <= 32'h0;
            di_q    <= 32'h0;
            dat_q   <= 32'h0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            tcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            we_q    <= we_d;
            a_q     <= a_d;
            di_q    <= di_d;
            dat_q   <= dat_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
`ifdef BRIDGE_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q & wbs_cyc_i;
    assign wbs_dat_o = dat_q;
    assign EN0       = en_q;
    assign WE0       = we_q;
    assign A0        = a_q;
    assign Di0       = di_q;

endmodule

// File: tb/tb_wb_bram_bridge.sv
// Scoreboard bench for wb_bram_bridge with a fixed-latency BRAM model.
module tb_wb_bram_bridge;

    localparam int TMO = 8;
`ifdef BRIDGE_TIMEOUT_EN
    localparam int MLAT = 5;
`else
    localparam int MLAT = 12;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        EN0;
    logic [3:0]  WE0;
    logic [31:0] A0, Di0;
    logic [31:0] Do0;
    logic        READY;
    logic        TIMEOUT_ERR;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] expq[$];
    logic [31:0] mem[0:255];
    int          mcnt;
    logic        ready_dis;

    wb_bram_bridge #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0),
        .Do0(Do0), .READY(READY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // BRAM model: READY pulses after EN0 has been seen for MLAT edges
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            READY <= 1'b0;
            mcnt  <= 0;
            Do0   <= 32'h0;
        end else if (READY) begin
            READY <= 1'b0;
            mcnt  <= 0;
        end else if (EN0 && !ready_dis) begin
            if (mcnt == MLAT - 1) begin
                READY <= 1'b1;
                Do0   <= mem[A0[7:0]];
                if (|WE0) mem[A0[7:0]] <= merge(mem[A0[7:0]], Di0, WE0);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && wbs_ack_o === 1'b1) begin
            if (!wbs_cyc_i || expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_ack: got ack=1 cyc=%b want no ack",
                         wbs_cyc_i);
            end else begin
                chk("rd_data", wbs_dat_o, expq.pop_front());
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp, output int lat,
                        output int encnt, output logic [31:0] a0f,
                        output logic [3:0] we0f, output logic stable);
        int n;
        expq.push_back(we ? 32'h0 : exp);
        @(negedge CLK);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        n = 0;
        encnt = 0;
        stable = 1'b1;
        a0f = 32'h0;
        we0f = 4'h0;
        while (n < 200) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                a0f  = A0;
                we0f = WE0;
            end
            if (EN0) begin
                encnt++;
                if (A0 !== a0f || WE0 !== we0f) stable = 1'b0;
            end
            if (wbs_ack_o) break;
        end
        lat = n;
        wbs_stb_i = 1'b0;
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_wait: got no ack want ack within 200");
            void'(expq.pop_front());
        end
        @(negedge CLK);
        chk("ack_one_cycle", {31'h0, wbs_ack_o}, 32'h0);
        wbs_cyc_i = 1'b0;
    endtask

    initial begin
        int          lat, enc;
        logic [31:0] a0f;
        logic [3:0]  we0f;
        logic        stb;

        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, enc;
        logic [31:0] a0f;
        logic [3:0]  we0f;
        logic        stb;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ready_dis = 1'b0;
        RST_N     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        #1;
        chk("rst_EN0", {31'h0, EN0}, 32'h0);
        chk("rst_WE0", {28'h0, WE0}, 32'h0);
        chk("rst_A0", A0, 32'h0);
        chk("rst_Di0", Di0, 32'h0);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_terr", {31'h0, TIMEOUT_ERR}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        xfer(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 32'h0,
             lat, enc, a0f, we0f, stb);
        chk("wr_A0", a0f, 32'h4);
        chk("wr_WE0", {28'h0, we0f}, 32'hF);
        chk("wr_stable", {31'h0, stb}, 32'h1);
        chk("wr_latency", lat, MLAT + 2);
        chk("wr_en_cycles", enc, MLAT + 1);
        chk("wr_dat_zero", wbs_dat_o, 32'h0);

        xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'hA5A5_1234,
             lat, enc, a0f, we0f, stb);
        chk("rd_WE0", {28'h0, we0f}, 32'h0);
        chk("rd_latency", lat, MLAT + 2);
        chk("rd_en_cycles", enc, MLAT + 1);

        xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0,
             lat, enc, a0f, we0f, stb);
        xfer(1'b1, 32'h20, 32'hFFFF_00BB, 4'h3, 32'h0,
             lat, enc, a0f, we0f, stb);
        chk("part_WE0", {28'h0, we0f}, 32'h3);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, 32'h1122_00BB,
             lat, enc, a0f, we0f, stb);

        // abandoned cycle: EN0 must ride out the memory latency
        @(negedge CLK);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h10;
        enc = 0;
        repeat (3) begin
            @(negedge CLK);
            if (EN0) enc++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!EN0) break;
            enc++;
        end
        chk("abort_en_cycles", enc, MLAT + 1);
        wbs_cyc_i = 1'b1;
        #2;
        chk("abort_no_ack", {31'h0, wbs_ack_o}, 32'h0);
        @(negedge CLK);
        wbs_cyc_i = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'hA5A5_1234,
             lat, enc, a0f, we0f, stb);
        chk("post_abort_lat", lat, MLAT + 2);

        // reset in the middle of a request
        @(negedge CLK);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = 32'h20;
        repeat (4) @(negedge CLK);
        chk("pre_rst_EN0", {31'h0, EN0}, 32'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_EN0", {31'h0, EN0}, 32'h0);
        chk("mid_rst_A0", A0, 32'h0);
        chk("mid_rst_dat", wbs_dat_o, 32'h0);
        chk("mid_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        enc = 0;
        repeat (20) begin
            @(negedge CLK);
            if (EN0) enc++;
        end
        chk("post_rst_en", enc, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, 32'h1122_00BB,
             lat, enc, a0f, we0f, stb);

`ifdef BRIDGE_TIMEOUT_EN
        ready_dis = 1'b1;
        xfer(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_BEEF,
             lat, enc, a0f, we0f, stb);
        chk("tmo_en_cycles", enc, TMO);
        chk("tmo_latency", lat, TMO + 1);
        chk("tmo_err", {31'h0, TIMEOUT_ERR}, 32'h1);
        repeat (5) @(negedge CLK);
        chk("tmo_err_sticky", {31'h0, TIMEOUT_ERR}, 32'h1);
        RST_N = 1'b0;
        #1;
        chk("tmo_err_rst", {31'h0, TIMEOUT_ERR}, 32'h0);
        ready_dis = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
`else
        chk("terr_tied", {31'h0, TIMEOUT_ERR}, 32'h0);
`endif

        repeat (4) @(negedge CLK);
        chk("queue_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_bram_bridge.md
WB_BRAM_BRIDGE -- requirements
Module: wb_bram_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles waiting for READY (timeout build only).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 SHALL have port CLK, input, 1: sole clock, all logic rising-edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, inputs, 1 each: Wishbone classic cycle, strobe, write.
REQ-006 SHALL have port wbs_sel_i, input, 4: byte lanes.
REQ-007 SHALL have ports wbs_adr_i and wbs_dat_i, inputs, 32 each: byte address and write data.
REQ-008 SHALL have ports wbs_ack_o, output, 1, and wbs_dat_o, output, 32: acknowledge and read data.
REQ-009 SHALL have ports EN0, output, 1; WE0, output, 4; A0, output, 32; Di0, output, 32: memory request.
REQ-010 SHALL have ports Do0, input, 32, and READY, input, 1: memory read data and completion pulse.
REQ-011 SHALL have port TIMEOUT_ERR, output, 1: sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, RESP.
REQ-013 IDLE: when wbs_cyc_i & wbs_stb_i, SHALL register A0 = {2'b0, wbs_adr_i[31:2]}, Di0 = wbs_dat_i, WE0 = wbs_we_i ? wbs_sel_i : 4'b0, set EN0=1, enter REQ.
REQ-014 REQ: EN0, A0, WE0, Di0 SHALL remain stable until the cycle READY=1 is sampled.
REQ-015 In the READY cycle SHALL capture Do0 into wbs_dat_o (reads only; writes return 0), drop EN0 and WE0 next edge, enter RESP.
REQ-016 RESP: wbs_ack_o SHALL be high exactly one cycle, then IDLE; latency from request accept to ack = memory latency + 2 cycles (14 for a 12-cycle memory).
REQ-017 SHALL not accept a new request in REQ or RESP; back-to-back strobes accepted from IDLE the cycle after ack.
REQ-018 If wbs_cyc_i drops while in REQ, SHALL keep EN0 asserted until READY (memory counter integrity) and SHALL suppress the ack.
REQ-019 wbs_ack_o SHALL never assert while wbs_cyc_i is low.
REQ-020 READY sampled while not in REQ SHALL be ignored.
REQ-021 EN0 SHALL be low in IDLE and RESP.

Reset
REQ-022 On RST_N low (async) SHALL force IDLE; EN0=0, WE0=0, A0=0, Di0=0, wbs_ack_o=0, wbs_dat_o=0, TIMEOUT_ERR=0, timeout counter=0.
REQ-023 Reset mid-REQ SHALL drop EN0 immediately; no ack issued after release.
REQ-024 Reset release SHALL take effect on the first CLK edge after RST_N rises.

Configuration
REQ-025 Macro BRIDGE_TIMEOUT_EN defined: counter runs in REQ; at TIMEOUT cycles without READY SHALL drop EN0, set TIMEOUT_ERR=1 (sticky until reset), enter RESP with wbs_dat_o=ERR_DATA.
REQ-026 Macro BRIDGE_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for READY; TIMEOUT_ERR tied 0.

Verification
REQ-027 Write adr=0x0000_0010, dat=0xA5A5_1234, sel=4'hF -> A0=4, WE0=4'hF held until READY; one ack cycle; later read same address returns 0xA5A5_1234.
REQ-028 Write sel=4'h3 dat=0xFFFF_00BB over 0x1122_3344 -> read returns 0x1122_00BB.
REQ-029 Read with 12-cycle memory -> ack exactly 14 cycles after strobe accept; EN0 high 13 cycles.
REQ-030 Drop wbs_cyc_i 3 cycles into REQ -> EN0 held until READY, no ack; next request completes normally.
REQ-031 BRIDGE_TIMEOUT_EN, TIMEOUT=8, READY tied 0 -> EN0 drops after 8 cycles, ack with 0xDEAD_BEEF, TIMEOUT_ERR=1 until RST_N low.
REQ-032 Assert RST_N low mid-REQ -> EN0=0 same cycle, all outputs reset values, no spurious ack.
